// File: rtl/sequence_stepper_pkg.sv
// Shared types and defaults for the sequence stepper: FSM state encoding,
// default widths and the minimum step length the prefetch can sustain.
package sequence_stepper_pkg;

   localparam int ADDR_W_DEF   = 10;
   localparam int DATA_W_DEF   = 128;
   localparam int CNT_W_DEF    = 32;
   localparam int MIN_STEP_LEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_FETCH,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sequence_stepper_if.sv
// BRAM read port between the sequence stepper (master) and the table memory (slave).
interface sequence_stepper_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 128
);
   logic [ADDR_W-1:0] bram_addr;
   logic              bram_en;
   logic [DATA_W-1:0] bram_rdata;

   modport master (output bram_addr, output bram_en, input  bram_rdata);
   modport slave  (input  bram_addr, input  bram_en, output bram_rdata);
endinterface

// File: rtl/sequence_stepper_step_counter.sv
// Sample-tick down-counter: loads step_len-1, reloads itself on terminal count
// and flags the tick that completes a step.
module sequence_stepper_step_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             clear,
   input  logic             load,
   input  logic             tick,
   input  logic [CNT_W-1:0] reload,
   output logic             term
);
   logic [CNT_W-1:0] cnt;

   assign term = tick && !clear && !load && (cnt == '0);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (load || term)
         cnt <= reload;
      else if (tick)
         cnt <= cnt - CNT_W'(1);
   end
endmodule

// File: rtl/sequence_stepper.sv
// Plays table entries out of BRAM one step per step_len sample ticks, with
// the next entry prefetched so seq_data changes exactly on step boundaries.
//
//   state | meaning
//   IDLE  | outputs cleared, waiting for an enable rising edge
//   PRIME | first read in flight, waiting for entry 0
//   FETCH | stepping; read for the next entry outstanding
//   RUN   | stepping; next entry held in prefetch (or table exhausted)
//   DONE  | one-shot finished, waiting for enable low
module sequence_stepper
   import sequence_stepper_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic                 loop_en,
   input  logic                 sample_tick,
   input  logic [CNT_W-1:0]     step_len,
   input  logic [ADDR_W:0]      num_steps,
   sequence_stepper_if.master   bram,
   output logic [DATA_W-1:0]    seq_data,
   output logic [ADDR_W-1:0]    step_idx,
   output logic                 step_tick,
   output logic                 running,
   output logic                 done
);
   state_t            state, state_nxt;
   logic              en_prev_low, loop_q, rdv, eot;
   logic [CNT_W-1:0]  len_q;
   logic [ADDR_W:0]   nsteps_q;
   logic [DATA_W-1:0] pf;
   logic [ADDR_W-1:0] f_idx, fol_idx, issue_addr;
   logic              start, last, have_fol, cnt_tick, cnt_load, cnt_term;
   logic              step, finish, issue;
   logic [DATA_W-1:0] step_data;

   // en_prev_low resets low so a reset with enable held high does not restart
   assign start     = enable && en_prev_low;
   assign last      = ({1'b0, f_idx} == nsteps_q - (ADDR_W+1)'(1));
   assign fol_idx   = last ? '0 : f_idx + ADDR_W'(1);
   assign have_fol  = !last || loop_q;
   assign cnt_tick  = enable && sample_tick && (state == ST_FETCH || state == ST_RUN);
   assign cnt_load  = (state == ST_PRIME) && rdv;
   assign step_data = (state == ST_PRIME || rdv) ? bram.bram_rdata : pf;

   sequence_stepper_step_counter #(.CNT_W(CNT_W)) u_step_counter (
      .clk     (clk),
      .aresetn (aresetn),
      .clear   (state == ST_IDLE),
      .load    (cnt_load),
      .tick    (cnt_tick),
      .reload  (len_q - CNT_W'(1)),
      .term    (cnt_term)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      step       = 1'b0;
      finish     = 1'b0;
      issue      = 1'b0;
      issue_addr = fol_idx;
      unique case (state)
         ST_IDLE:
            if (start) begin
               if (num_steps == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt  = ST_PRIME;
                  issue      = 1'b1;
                  issue_addr = '0;
               end
            end
         ST_PRIME:
            if (rdv) begin
               step      = 1'b1;
               issue     = have_fol;
               state_nxt = have_fol ? ST_FETCH : ST_RUN;
            end
         ST_FETCH, ST_RUN:
            if (cnt_term) begin
               if (eot) begin
                  finish    = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  step      = 1'b1;
                  issue     = have_fol;
                  state_nxt = have_fol ? ST_FETCH : ST_RUN;
               end
            end else if (state == ST_FETCH && rdv) begin
               state_nxt = ST_RUN;
            end
         ST_DONE: ;
         default: state_nxt = ST_IDLE;
      endcase
      if (!enable) begin
         state_nxt = ST_IDLE;
         step      = 1'b0;
         finish    = 1'b0;
         issue     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         en_prev_low    <= 1'b0;
         loop_q         <= 1'b0;
         len_q          <= '0;
         nsteps_q       <= '0;
         rdv            <= 1'b0;
         eot            <= 1'b0;
         pf             <= '0;
         f_idx          <= '0;
         bram.bram_en   <= 1'b0;
         bram.bram_addr <= '0;
         seq_data       <= '0;
         step_idx       <= '0;
         step_tick      <= 1'b0;
         running        <= 1'b0;
         done           <= 1'b0;
      end else begin
         en_prev_low  <= !enable;
         rdv          <= bram.bram_en && enable;
         bram.bram_en <= issue;
         step_tick    <= step;
         running      <= state_nxt inside {ST_PRIME, ST_FETCH, ST_RUN};
         done         <= (state_nxt == ST_DONE);
         if (issue)
            bram.bram_addr <= issue_addr;
         if (rdv)
            pf <= bram.bram_rdata;
         if (state == ST_IDLE && start) begin
            loop_q   <= loop_en;
            len_q    <= (step_len < CNT_W'(MIN_STEP_LEN)) ? CNT_W'(MIN_STEP_LEN) : step_len;
            nsteps_q <= num_steps;
            f_idx    <= '0;
            eot      <= 1'b0;
         end
         if (step) begin
            seq_data <= step_data;
            step_idx <= f_idx;
            eot      <= !have_fol;
            if (have_fol)
               f_idx <= fol_idx;
         end
         if (finish || !enable) begin
            seq_data <= '0;
            step_idx <= '0;
         end
      end
   end
endmodule

// File: tb/tb_sequence_stepper.sv
// Bench for sequence_stepper: vector table of playback configurations, an
// event-level reference model of step boundaries, abort/reset sequences and random runs.
module tb_sequence_stepper;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 128;
   localparam int CNT_W  = 32;
   localparam int MAXC   = 2200;
   localparam int NV     = 8;

   logic              clk = 1'b0;
   logic              aresetn, enable, loop_en, sample_tick;
   logic [CNT_W-1:0]  step_len;
   logic [ADDR_W:0]   num_steps;
   logic [DATA_W-1:0] seq_data;
   logic [ADDR_W-1:0] step_idx;
   logic              step_tick, running, done;

   int errors = 0;
   int checks = 0;
   int cur_r  = 0;

   int tk_a   [MAXC];
   int eidx_a [MAXC];
   bit etk_a  [MAXC];
   bit edone_a[MAXC];
   bit erun_a [MAXC];

   typedef struct {
      int n;
      int len;
      bit lp;
      int period;
      int cycles;
      int exp_steps;
      bit exp_done;
      int exp_idx;
      int exp_hold;
      int exp_reads;
   } vec_t;
   vec_t vecs[NV];

   sequence_stepper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sequence_stepper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .enable      (enable),
      .loop_en     (loop_en),
      .sample_tick (sample_tick),
      .step_len    (step_len),
      .num_steps   (num_steps),
      .bram        (bus),
      .seq_data    (seq_data),
      .step_idx    (step_idx),
      .step_tick   (step_tick),
      .running     (running),
      .done        (done)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] entry(input int k);
      logic [7:0] b;
      b = k[7:0];
      return {16{b}};
   endfunction

   always @(posedge clk) begin
      if (bus.bram_en)
         bus.bram_rdata <= entry(int'(bus.bram_addr));
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at r=%0d: got %0h, expected %0h", name, cur_r, got, exp);
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   // Expected per-edge outputs from the playback rules: first entry two edges
   // after the start edge, then a boundary on every step_len-th tick after it.
   task automatic build_model(input int n, input int len, input bit lp, input int period, input int cycles);
      int eff, b, e, cnt, idx, end_r;
      for (int r = 0; r < MAXC; r++) begin
         tk_a[r]    = (period == 0) ? int'($urandom_range(0, 1)) : int'((r % period) == 0);
         eidx_a[r]  = -1;
         etk_a[r]   = 1'b0;
         edone_a[r] = 1'b0;
         erun_a[r]  = 1'b0;
      end
      end_r = -1;
      if (n == 0) begin
         end_r = 0;
      end else begin
         eff = (len < 2) ? 2 : len;
         b   = 2;
         idx = 0;
         while (b <= cycles) begin
            etk_a[b] = 1'b1;
            cnt = 0;
            e   = b;
            while (cnt < eff && e < MAXC - 1) begin
               e++;
               cnt += tk_a[e];
            end
            for (int r = b; r < e && r <= cycles; r++)
               eidx_a[r] = idx;
            if (cnt < eff)
               break;
            if (idx == n - 1 && !lp) begin
               end_r = e;
               break;
            end
            idx = (idx + 1 == n) ? 0 : idx + 1;
            b   = e;
         end
      end
      for (int r = 0; r <= cycles; r++) begin
         edone_a[r] = (end_r >= 0) && (r >= end_r);
         erun_a[r]  = !edone_a[r];
      end
   endtask

   task automatic run_case(input int n, input int len, input bit lp, input int period, input int cycles,
                           output int steps, output bit fin_done, output int fin_idx,
                           output int hold, output int reads);
      int t2, t3;
      logic [DATA_W-1:0] exp_data;
      build_model(n, len, lp, period, cycles);
      enable      = 1'b0;
      sample_tick = 1'b0;
      tick_clk();
      tick_clk();
      num_steps   = (ADDR_W+1)'(n);
      step_len    = CNT_W'(len);
      loop_en     = lp;
      sample_tick = (tk_a[0] != 0);
      enable      = 1'b1;
      steps = 0; reads = 0; t2 = -1; t3 = -1;
      for (int r = 0; r <= cycles; r++) begin
         tick_clk();
         cur_r    = r;
         exp_data = (eidx_a[r] < 0) ? '0 : entry(eidx_a[r]);
         chk("seq_data", seq_data, exp_data);
         chk("step_tick", DATA_W'(step_tick), DATA_W'(etk_a[r]));
         chk("done", DATA_W'(done), DATA_W'(edone_a[r]));
         chk("running", DATA_W'(running), DATA_W'(erun_a[r]));
         if (eidx_a[r] >= 0)
            chk("step_idx", DATA_W'(step_idx), DATA_W'(eidx_a[r]));
         if (step_tick) begin
            steps++;
            if (steps == 2) t2 = r;
            if (steps == 3) t3 = r;
         end
         if (bus.bram_en)
            reads++;
         // config must be ignored once playback has started
         sample_tick = (tk_a[r+1] != 0);
         num_steps   = (ADDR_W+1)'($urandom);
         step_len    = CNT_W'($urandom_range(0, 7));
         loop_en     = 1'($urandom);
      end
      fin_done = done;
      fin_idx  = int'(step_idx);
      hold     = (t3 >= 0) ? t3 - t2 : 0;
      enable   = 1'b0;
   endtask

   task automatic start_play(input int n, input int len, input bit lp);
      enable = 1'b0;
      tick_clk();
      tick_clk();
      num_steps   = (ADDR_W+1)'(n);
      step_len    = CNT_W'(len);
      loop_en     = lp;
      sample_tick = 1'b1;
      enable      = 1'b1;
      tick_clk();
   endtask

   initial begin
      int steps, fin_idx, hold, reads;
      bit fin_done;

      //           n    len lp per cyc   steps done idx hold reads
      vecs[0] = '{4,    3, 1'b0, 1, 20,     4, 1'b1, 0, 3,    4};
      vecs[1] = '{4,    3, 1'b1, 1, 31,    10, 1'b0, 1, 3,   11};
      vecs[2] = '{4,    1, 1'b0, 5, 60,     4, 1'b1, 0, 10,   4};
      vecs[3] = '{1,    2, 1'b0, 1, 10,     1, 1'b1, 0, 0,    1};
      vecs[4] = '{0,    3, 1'b0, 1, 5,      0, 1'b1, 0, 0,    0};
      vecs[5] = '{1,    2, 1'b1, 1, 11,     5, 1'b0, 0, 2,    6};
      vecs[6] = '{2,    0, 1'b1, 1, 13,     6, 1'b0, 1, 2,    7};
      vecs[7] = '{1024, 2, 1'b1, 1, 2060, 1030, 1'b0, 5, 2, 1031};

      aresetn = 1'b0; enable = 1'b1; loop_en = 1'b0; sample_tick = 1'b1;
      step_len = 32'd3; num_steps = 11'd4;
      #23;
      cur_r = 0;
      chk("reset_seq_data", seq_data, '0);
      chk("reset_running", DATA_W'(running), '0);
      chk("reset_bram_en", DATA_W'(bus.bram_en), '0);
      aresetn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         run_case(vecs[i].n, vecs[i].len, vecs[i].lp, vecs[i].period, vecs[i].cycles,
                  steps, fin_done, fin_idx, hold, reads);
         cur_r = i;
         chk("vec_steps", DATA_W'(steps), DATA_W'(vecs[i].exp_steps));
         chk("vec_done", DATA_W'(fin_done), DATA_W'(vecs[i].exp_done));
         chk("vec_idx", DATA_W'(fin_idx), DATA_W'(vecs[i].exp_idx));
         chk("vec_hold", DATA_W'(hold), DATA_W'(vecs[i].exp_hold));
         chk("vec_reads", DATA_W'(reads), DATA_W'(vecs[i].exp_reads));
      end

      // abort while entry 2 is showing, then restart from entry 0
      start_play(4, 3, 1'b0);
      repeat (8) tick_clk();
      cur_r = 8;
      chk("abort_pre_idx", DATA_W'(step_idx), DATA_W'(2));
      enable = 1'b0;
      tick_clk();
      cur_r = 9;
      chk("abort_seq_data", seq_data, '0);
      chk("abort_running", DATA_W'(running), '0);
      chk("abort_done", DATA_W'(done), '0);
      tick_clk();
      enable = 1'b1;
      tick_clk();
      tick_clk();
      cur_r = 12;
      chk("restart_early", seq_data, '0);
      tick_clk();
      cur_r = 13;
      chk("restart_data", seq_data, entry(0));
      chk("restart_idx", DATA_W'(step_idx), '0);
      chk("restart_tick", DATA_W'(step_tick), DATA_W'(1));

      // asynchronous reset in the middle of step 1
      start_play(4, 3, 1'b1);
      repeat (6) tick_clk();
      cur_r = 6;
      chk("rst_pre_idx", DATA_W'(step_idx), DATA_W'(1));
      #2 aresetn = 1'b0;
      #1;
      chk("rst_seq_data", seq_data, '0);
      chk("rst_step_idx", DATA_W'(step_idx), '0);
      chk("rst_running", DATA_W'(running), '0);
      chk("rst_bram_en", DATA_W'(bus.bram_en), '0);
      #2 aresetn = 1'b1;
      reads = 0;
      for (int r = 0; r < 6; r++) begin
         tick_clk();
         if (bus.bram_en || seq_data != '0 || running)
            reads++;
      end
      chk("rst_quiet", DATA_W'(reads), '0);
      enable = 1'b0;
      tick_clk();
      enable = 1'b1;
      tick_clk();
      tick_clk();
      tick_clk();
      cur_r = 2;
      chk("rst_restart_data", seq_data, entry(0));
      chk("rst_restart_tick", DATA_W'(step_tick), DATA_W'(1));

      for (int i = 0; i < 6; i++) begin
         run_case($urandom_range(1, 6), $urandom_range(0, 5), 1'($urandom), 0, 80,
                  steps, fin_done, fin_idx, hold, reads);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
